// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// the data-memory wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mw_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait FSM: holds mem_stall for MEM_LAT-1 cycles per access in M,
// then releases for exactly one cycle so the access can leave M.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic memaccess_M,
  output logic mem_stall
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

  mw_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The release cycle (WAIT, cnt==0) always returns to RUN, so an access that
  // is still sitting in M during release cannot re-trigger the wait.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    case (state)
      RUN: begin
        if (memaccess_M && (MEM_LAT > 1)) begin
          mem_stall  = 1'b1;
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          mem_stall = 1'b1;
          cnt_next  = cnt - CNT_W'(1);
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding for E, load-use bubbles,
// taken-branch squashing, memory-wait freeze and a saturating stall counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int N        = 32,
  parameter int REG_W    = 4,
  parameter int MEM_LAT  = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rs1_E,
  input  logic [REG_W-1:0] rs2_E,
  input  logic [REG_W-1:0] rd_E,
  input  logic [REG_W-1:0] rd_M,
  input  logic [REG_W-1:0] rd_W,
  input  logic             regwrite_E,
  input  logic             regwrite_M,
  input  logic             regwrite_W,
  input  logic             memread_E,
  input  logic             memaccess_M,
  input  logic             branch_taken_E,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_F,
  output logic             flush_E,
  output logic             flush_W,
  output logic [N-1:0]     perf_stall
);

  logic     mem_stall;
  logic     load_use;
  fwd_sel_t fwd_a, fwd_b;

  mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mem_wait (
    .clk         (clk),
    .rst         (rst),
    .memaccess_M (memaccess_M),
    .mem_stall   (mem_stall)
  );

  // Register match that ignores the hardwired zero register when enabled.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // M is checked last so it wins over W when both hold the register.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (regwrite_W && reg_match(rd_W, rs1_E)) fwd_a = FWD_WB;
    if (regwrite_M && reg_match(rd_M, rs1_E)) fwd_a = FWD_MEM;
    if (regwrite_W && reg_match(rd_W, rs2_E)) fwd_b = FWD_WB;
    if (regwrite_M && reg_match(rd_M, rs2_E)) fwd_b = FWD_MEM;
  end

  assign load_use = memread_E && regwrite_E &&
                    (reg_match(rd_E, rs1_D) || reg_match(rd_E, rs2_D));

  // Priority: reset, then memory freeze, then taken branch, then load-use.
  always_comb begin
    fwd_a_E = fwd_a;
    fwd_b_E = fwd_b;
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_F = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (!rst) begin
      fwd_a_E = FWD_RF;
      fwd_b_E = FWD_RF;
      flush_F = 1'b1;
      flush_E = 1'b1;
      flush_W = 1'b1;
    end else if (mem_stall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (branch_taken_E) begin
      flush_F = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall <= '0;
    end else if (stall_D && (perf_stall != {N{1'b1}})) begin
      perf_stall <= perf_stall + N'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (MEM_LAT=3, MEM_LAT=4 with
// zero register and 4-bit counter, MEM_LAT=1) share one stimulus stream.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       regwrite_E, regwrite_M, regwrite_W;
  logic       memread_E, memaccess_M, branch_taken_E;

  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic [2:0]  s_f, s_d, s_e, s_m, f_f, f_e, f_w;
  logic [31:0] perf0, perf2;
  logic [3:0]  perf1;
  logic [6:0]  ctl [3];

  int errors = 0;
  int checks = 0;

  // ctl bit order: {stall_F, stall_D, stall_E, stall_M, flush_F, flush_E, flush_W}
  assign ctl[0] = {s_f[0], s_d[0], s_e[0], s_m[0], f_f[0], f_e[0], f_w[0]};
  assign ctl[1] = {s_f[1], s_d[1], s_e[1], s_m[1], f_f[1], f_e[1], f_w[1]};
  assign ctl[2] = {s_f[2], s_d[2], s_e[2], s_m[2], f_f[2], f_e[2], f_w[2]};

  hazard_unit #(.N(32), .REG_W(4), .MEM_LAT(3), .ZERO_REG(0)) u_main (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .regwrite_E(regwrite_E), .regwrite_M(regwrite_M),
    .regwrite_W(regwrite_W), .memread_E(memread_E), .memaccess_M(memaccess_M),
    .branch_taken_E(branch_taken_E), .fwd_a_E(fa[0]), .fwd_b_E(fb[0]),
    .stall_F(s_f[0]), .stall_D(s_d[0]), .stall_E(s_e[0]), .stall_M(s_m[0]),
    .flush_F(f_f[0]), .flush_E(f_e[0]), .flush_W(f_w[0]), .perf_stall(perf0));

  hazard_unit #(.N(4), .REG_W(4), .MEM_LAT(4), .ZERO_REG(1)) u_zero (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .regwrite_E(regwrite_E), .regwrite_M(regwrite_M),
    .regwrite_W(regwrite_W), .memread_E(memread_E), .memaccess_M(memaccess_M),
    .branch_taken_E(branch_taken_E), .fwd_a_E(fa[1]), .fwd_b_E(fb[1]),
    .stall_F(s_f[1]), .stall_D(s_d[1]), .stall_E(s_e[1]), .stall_M(s_m[1]),
    .flush_F(f_f[1]), .flush_E(f_e[1]), .flush_W(f_w[1]), .perf_stall(perf1));

  hazard_unit #(.N(32), .REG_W(4), .MEM_LAT(1), .ZERO_REG(0)) u_lat1 (
    .clk(clk), .rst(rst), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W), .regwrite_E(regwrite_E), .regwrite_M(regwrite_M),
    .regwrite_W(regwrite_W), .memread_E(memread_E), .memaccess_M(memaccess_M),
    .branch_taken_E(branch_taken_E), .fwd_a_E(fa[2]), .fwd_b_E(fb[2]),
    .stall_F(s_f[2]), .stall_D(s_d[2]), .stall_E(s_e[2]), .stall_M(s_m[2]),
    .flush_F(f_f[2]), .flush_E(f_e[2]), .flush_W(f_w[2]), .perf_stall(perf2));

  task automatic clear_inputs;
    rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0;
    rd_E = '0; rd_M = '0; rd_W = '0;
    regwrite_E = 1'b0; regwrite_M = 1'b0; regwrite_W = 1'b0;
    memread_E = 1'b0; memaccess_M = 1'b0; branch_taken_E = 1'b0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    rs1_E = 4'd3; rd_M = 4'd3; regwrite_M = 1'b1; memaccess_M = 1'b1;
    next_cycle();
    next_cycle();
    sample();
    checks++; if (ctl[0] !== 7'b0000111) begin errors++; $display("FAIL reset_ctl_main: got %b expected %b", ctl[0], 7'b0000111); end
    checks++; if (ctl[1] !== 7'b0000111) begin errors++; $display("FAIL reset_ctl_zero: got %b expected %b", ctl[1], 7'b0000111); end
    checks++; if (fa[0] !== 2'b00) begin errors++; $display("FAIL reset_fwd: got %b expected %b", fa[0], 2'b00); end
    checks++; if (perf0 !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", perf0); end
    next_cycle();
    rst = 1'b1;
    clear_inputs();
  endtask

  task automatic test_forwarding;
    next_cycle();
    clear_inputs();
    rs1_E = 4'd3; rd_M = 4'd3; regwrite_M = 1'b1; rd_W = 4'd3; regwrite_W = 1'b1;
    sample();
    checks++; if (fa[0] !== 2'b10) begin errors++; $display("FAIL fwd_mem_priority: got %b expected %b", fa[0], 2'b10); end
    checks++; if (ctl[0] !== 7'b0) begin errors++; $display("FAIL fwd_no_ctl: got %b expected %b", ctl[0], 7'b0); end
    next_cycle();
    regwrite_M = 1'b0;
    sample();
    checks++; if (fa[0] !== 2'b01) begin errors++; $display("FAIL fwd_wb: got %b expected %b", fa[0], 2'b01); end
    next_cycle();
    clear_inputs();
    rs2_E = 4'd7; rd_M = 4'd7; rd_W = 4'd7; regwrite_W = 1'b1;
    sample();
    checks++; if (fb[0] !== 2'b01) begin errors++; $display("FAIL fwd_b_wb: got %b expected %b", fb[0], 2'b01); end
    checks++; if (fa[0] !== 2'b00) begin errors++; $display("FAIL fwd_a_none: got %b expected %b", fa[0], 2'b00); end
    next_cycle();
    clear_inputs();
    regwrite_M = 1'b1; regwrite_W = 1'b1;
    sample();
    checks++; if (fa[1] !== 2'b00) begin errors++; $display("FAIL fwd_zero_reg_a: got %b expected %b", fa[1], 2'b00); end
    checks++; if (fb[1] !== 2'b00) begin errors++; $display("FAIL fwd_zero_reg_b: got %b expected %b", fb[1], 2'b00); end
    checks++; if (fa[0] !== 2'b10) begin errors++; $display("FAIL fwd_reg0_plain: got %b expected %b", fa[0], 2'b10); end
  endtask

  task automatic test_load_use;
    logic [31:0] p;
    next_cycle();
    clear_inputs();
    memread_E = 1'b1; regwrite_E = 1'b1; rd_E = 4'd5; rs2_D = 4'd5; rs1_D = 4'd1;
    sample();
    p = perf0;
    checks++; if (ctl[0] !== 7'b1100010) begin errors++; $display("FAIL load_use_rs2: got %b expected %b", ctl[0], 7'b1100010); end
    next_cycle();
    clear_inputs();
    rd_M = 4'd5; regwrite_M = 1'b1;
    sample();
    checks++; if (ctl[0] !== 7'b0) begin errors++; $display("FAIL load_use_clears: got %b expected %b", ctl[0], 7'b0); end
    checks++; if (perf0 !== p + 32'd1) begin errors++; $display("FAIL load_use_perf: got %0d expected %0d", perf0, p + 32'd1); end
    next_cycle();
    clear_inputs();
    memread_E = 1'b1; regwrite_E = 1'b1; rd_E = 4'd2; rs1_D = 4'd2; rs2_D = 4'd9;
    sample();
    checks++; if (ctl[0] !== 7'b1100010) begin errors++; $display("FAIL load_use_rs1: got %b expected %b", ctl[0], 7'b1100010); end
    next_cycle();
    regwrite_E = 1'b0;
    sample();
    checks++; if (ctl[0] !== 7'b0) begin errors++; $display("FAIL load_no_regwrite: got %b expected %b", ctl[0], 7'b0); end
    next_cycle();
    clear_inputs();
    memread_E = 1'b1; regwrite_E = 1'b1;
    sample();
    checks++; if (ctl[0] !== 7'b1100010) begin errors++; $display("FAIL load_use_reg0_plain: got %b expected %b", ctl[0], 7'b1100010); end
    checks++; if (ctl[1] !== 7'b0) begin errors++; $display("FAIL load_use_zero_reg: got %b expected %b", ctl[1], 7'b0); end
    next_cycle();
    clear_inputs();
  endtask

  // Six cycles of memaccess_M held high: two back-to-back accesses for MEM_LAT=3.
  task automatic test_mem_wait;
    logic [5:0]  main_pat;
    logic [5:0]  zero_pat;
    logic [6:0]  exp;
    logic [31:0] p;
    main_pat = 6'b110110;
    zero_pat = 6'b111011;
    next_cycle();
    clear_inputs();
    memaccess_M = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i == 0) p = perf0;
      exp = main_pat[5-i] ? 7'b1111001 : 7'b0;
      checks++; if (ctl[0] !== exp) begin errors++; $display("FAIL mem_wait_lat3 c%0d: got %b expected %b", i + 1, ctl[0], exp); end
      checks++; if (s_m[1] !== zero_pat[5-i]) begin errors++; $display("FAIL mem_wait_lat4 c%0d: got %b expected %b", i + 1, s_m[1], zero_pat[5-i]); end
      checks++; if (ctl[2] !== 7'b0) begin errors++; $display("FAIL mem_wait_lat1 c%0d: got %b expected %b", i + 1, ctl[2], 7'b0); end
      if (i < 5) next_cycle();
    end
    next_cycle();
    memaccess_M = 1'b0;
    sample();
    checks++; if (ctl[0] !== 7'b0) begin errors++; $display("FAIL mem_wait_idle: got %b expected %b", ctl[0], 7'b0); end
    checks++; if (perf0 !== p + 32'd4) begin errors++; $display("FAIL mem_wait_perf: got %0d expected %0d", perf0, p + 32'd4); end
    next_cycle();
    next_cycle();
    sample();
    checks++; if (s_m[1] !== 1'b0) begin errors++; $display("FAIL mem_wait_lat4_done: got %b expected %b", s_m[1], 1'b0); end
  endtask

  task automatic test_priority;
    logic [6:0] exp;
    next_cycle();
    clear_inputs();
    memread_E = 1'b1; regwrite_E = 1'b1; rd_E = 4'd5; rs1_D = 4'd5; branch_taken_E = 1'b1;
    sample();
    checks++; if (ctl[0] !== 7'b0000110) begin errors++; $display("FAIL branch_over_load_use: got %b expected %b", ctl[0], 7'b0000110); end
    next_cycle();
    clear_inputs();
    memaccess_M = 1'b1; branch_taken_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      exp = (i < 2) ? 7'b1111001 : 7'b0000110;
      checks++; if (ctl[0] !== exp) begin errors++; $display("FAIL branch_in_mem_stall c%0d: got %b expected %b", i + 1, ctl[0], exp); end
      if (i < 2) next_cycle();
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_wait;
    next_cycle();
    clear_inputs();
    memaccess_M = 1'b1;
    sample();
    checks++; if (s_m[1] !== 1'b1) begin errors++; $display("FAIL rst_wait_start: got %b expected %b", s_m[1], 1'b1); end
    next_cycle();
    rst = 1'b0;
    sample();
    checks++; if (ctl[1] !== 7'b0000111) begin errors++; $display("FAIL rst_wait_forced: got %b expected %b", ctl[1], 7'b0000111); end
    next_cycle();
    rst = 1'b1;
    memaccess_M = 1'b0;
    sample();
    checks++; if (ctl[1] !== 7'b0) begin errors++; $display("FAIL rst_wait_aborted: got %b expected %b", ctl[1], 7'b0); end
    checks++; if (perf1 !== 4'd0) begin errors++; $display("FAIL rst_wait_perf: got %0d expected 0", perf1); end
    next_cycle();
    sample();
    checks++; if (ctl[1] !== 7'b0) begin errors++; $display("FAIL rst_wait_run: got %b expected %b", ctl[1], 7'b0); end
  endtask

  task automatic test_saturation;
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    memread_E = 1'b1; regwrite_E = 1'b1; rd_E = 4'd4; rs1_D = 4'd4;
    repeat (20) next_cycle();
    sample();
    checks++; if (perf1 !== 4'd15) begin errors++; $display("FAIL perf_saturate: got %0d expected 15", perf1); end
    checks++; if (perf0 !== 32'd20) begin errors++; $display("FAIL perf_count20: got %0d expected 20", perf0); end
    checks++; if (ctl[1] !== 7'b1100010) begin errors++; $display("FAIL perf_still_stalling: got %b expected %b", ctl[1], 7'b1100010); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_priority();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
